mem_arbiter_n: RTL

Parametrised successor to the two-port memory controller. Serves NUM_CH requesters (ICache, LSB, future DCache/prefetch) over the single byte-serial RAM/IO bus, supporting 1/2/4-byte little-endian transfers. Arbitration is selectable between fixed priority and round-robin. Adds IO-write flow control against io_buffer_full and flush (clear) semantics. Sits between the requesters and the cpu top-level mem_* pins.

---
 rtl/mem_arb_pkg.sv | 31 +++
 rtl/mem_rr_arbiter.sv | 46 ++++
 rtl/mem_arbiter_n.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the byte-serial memory arbiter.
// Holds the controller state encoding, the IO-space decode and the transfer-length rules.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_XFER    = 2'd1,
        S_IO_WAIT = 2'd2,
        S_FINISH  = 2'd3
    } arb_state_t;

    // IO space is selected by address bits [17:16] == 2'b11.
    localparam int         IO_SEL_LSB = 16;
    localparam logic [1:0] IO_SPACE   = 2'b11;

    localparam logic [2:0] LEN_BYTE = 3'd1;
    localparam logic [2:0] LEN_HALF = 3'd2;
    localparam logic [2:0] LEN_WORD = 3'd4;

    // A length of 0 becomes one byte, and anything above a word becomes a word.
    function automatic logic [2:0] clamp_len(input logic [2:0] len);
        if (len == 3'd0) begin
            return LEN_BYTE;
        end else if (len > LEN_WORD) begin
            return LEN_WORD;
        end else begin
            return len;
        end
    endfunction

endpackage

// File: rtl/mem_rr_arbiter.sv
// Request arbiter: fixed priority (lowest index wins) or round-robin from a rotating pointer.
// The grant is combinational; the pointer advances to grant+1 only when the caller takes the grant.
module mem_rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int ARB_MODE = 0,
    localparam int PTR_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              en,
    input  logic              take,
    input  logic [NUM_CH-1:0] req,
    output logic              any,
    output logic [PTR_W-1:0]  grant_idx
);

    logic [PTR_W-1:0] rr_ptr;

    always_comb begin
        int start;
        int idx;
        // NOTE: every combinational output gets a default first, so no path leaves one unassigned and no latch is inferred.
        any       = 1'b0;
        grant_idx = '0;
        idx       = 0;
        start     = (ARB_MODE == 1) ? int'(rr_ptr) : 0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = (start + k) % NUM_CH;
            if (!any && req[idx]) begin
                any       = 1'b1;
                grant_idx = PTR_W'(idx);
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rr_ptr <= '0;
        end else if (en && take) begin
            rr_ptr <= (grant_idx == PTR_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter_n.sv
// NUM_CH-requester controller for the byte-serial RAM/IO bus with 1..4-byte little-endian transfers.
// It adds IO-write flow control against io_buffer_full and flush semantics that abort reads only.
module mem_arbiter_n
    import mem_arb_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int ARB_MODE = 0,
    parameter int ADDR_W   = 32,
    parameter int IO_GAP   = 1
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     clear,
    input  logic [NUM_CH-1:0]        req_valid,
    input  logic [NUM_CH-1:0]        req_we,
    input  logic [NUM_CH*ADDR_W-1:0] req_addr,
    input  logic [NUM_CH*32-1:0]     req_wdata,
    input  logic [NUM_CH*3-1:0]      req_len,
    output logic [NUM_CH-1:0]        resp_valid,
    output logic [31:0]              resp_data,
    input  logic [7:0]               mem_din,
    output logic [7:0]               mem_dout,
    output logic [ADDR_W-1:0]        mem_a,
    output logic                     mem_wr,
    input  logic                     io_buffer_full
);

    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    arb_state_t       state, state_d;
    logic             any_req;
    logic [PTR_W-1:0] grant_idx, cur_ch;
    logic [ADDR_W-1:0] addr_q;
    logic             we_q;
    logic [31:0]      wdata_q;
    logic [2:0]       len_q, cnt;
    logic [7:0]       gap_cnt;
    logic             pend_valid;
    logic [1:0]       pend_idx;
    logic             do_grant, issue, start_gap, gap_tick, do_resp;
    logic             is_io, io_block, abort, last_byte, all_sent;

    mem_rr_arbiter #(.NUM_CH(NUM_CH), .ARB_MODE(ARB_MODE)) u_arb (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .en        (rdy_in),
        .take      (do_grant),
        .req       (req_valid),
        .any       (any_req),
        .grant_idx (grant_idx)
    );

    always_comb begin
        is_io     = (addr_q[IO_SEL_LSB +: 2] == IO_SPACE);
        io_block  = we_q && is_io && io_buffer_full;
        abort     = clear && !we_q;
        last_byte = (cnt == len_q - 3'd1);
        all_sent  = (cnt == len_q);
        state_d   = state;
        do_grant  = 1'b0;
        issue     = 1'b0;
        start_gap = 1'b0;
        gap_tick  = 1'b0;
        do_resp   = 1'b0;
        mem_a     = '0;
        mem_dout  = '0;
        mem_wr    = 1'b0;
        unique case (state)
            S_IDLE: begin
                // The response cycle is itself IDLE; holding off here leaves one idle cycle between transfers.
                if (any_req && !clear && resp_valid == '0) begin
                    do_grant = 1'b1;
                    state_d  = S_XFER;
                end
            end
            S_XFER: begin
                mem_a    = addr_q + ADDR_W'(cnt);
                mem_dout = wdata_q[{cnt[1:0], 3'b000} +: 8];
                if (abort) begin
                    state_d = S_IDLE;
                end else if (io_block) begin
                    state_d = S_IO_WAIT;
                end else begin
                    issue  = 1'b1;
                    mem_wr = we_q && rdy_in;
                    if (we_q && is_io && IO_GAP > 0) begin
                        start_gap = 1'b1;
                        state_d   = S_IO_WAIT;
                    end else if (last_byte) begin
                        do_resp = we_q;
                        state_d = we_q ? S_IDLE : S_FINISH;
                    end
                end
            end
            S_IO_WAIT: begin
                if (gap_cnt != 8'd0) begin
                    gap_tick = 1'b1;
                    if (gap_cnt == 8'd1) begin
                        do_resp = all_sent;
                        state_d = all_sent ? S_IDLE : S_XFER;
                    end
                end else if (!io_buffer_full) begin
                    state_d = S_XFER;
                end
            end
            S_FINISH: begin
                do_resp = !abort;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state <= S_IDLE;
        end else if (rdy_in) begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cur_ch     <= '0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            len_q      <= LEN_BYTE;
            cnt        <= '0;
            gap_cnt    <= '0;
            pend_valid <= 1'b0;
            pend_idx   <= '0;
            resp_valid <= '0;
            resp_data  <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            if (rdy_in) begin
                resp_valid <= '0;
                if (do_resp) begin
                    resp_valid[cur_ch] <= 1'b1;
                end
                if (do_grant) begin
                    cur_ch    <= grant_idx;
                    addr_q    <= req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
                    we_q      <= req_we[grant_idx];
                    wdata_q   <= req_wdata[int'(grant_idx)*32 +: 32];
                    len_q     <= clamp_len(req_len[int'(grant_idx)*3 +: 3]);
                    cnt       <= '0;
                    resp_data <= '0;
                end
                if (issue) begin
                    cnt <= cnt + 3'd1;
                end
                if (start_gap) begin
                    gap_cnt <= 8'(IO_GAP);
                end else if (gap_tick) begin
                    gap_cnt <= gap_cnt - 8'd1;
                end
            end
            // The RAM answers one cycle after any address regardless of rdy_in, so capture tracks the bus.
            pend_valid <= issue && !we_q && rdy_in;
            pend_idx   <= cnt[1:0];
            if (pend_valid) begin
                resp_data[{pend_idx, 3'b000} +: 8] <= mem_din;
            end
        end
    end

endmodule
